// File: rtl/line_memory_responder_pkg.sv
// ============================================================================
// Module   : line_memory_responder_pkg
// Purpose  : Shared line geometry and FSM state encoding for the line responder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_memory_responder_pkg;

    localparam int LINE_WORDS       = 4;
    localparam int WORD_BITS        = 32;
    localparam int LINE_BITS        = LINE_WORDS * WORD_BITS;
    localparam int LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/line_memory_responder_line_store.sv
// ============================================================================
// Module   : line_store
// Purpose  : Line-wide storage array; write committed on the clock edge, read
//            data presented for the responder to register at completion
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_store
    import line_memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [LINE_BITS-1:0]  i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [LINE_BITS-1:0]  o_rd_data
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    // Zero image at time 0 so never-written lines read back as zero.
    logic [LINE_BITS-1:0] mem_q [c_depth] = '{default: '0};

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/line_memory_responder.sv
// ============================================================================
// Module   : line_memory_responder
// Purpose  : Fixed-latency line read/write responder with BUSYWAIT stall
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_memory_responder
    import line_memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 READ,
    input  logic                 WRITE,
    input  logic [31:0]          ADDRESS,
    input  logic [LINE_BITS-1:0] WRITEDATA,
    output logic [LINE_BITS-1:0] READDATA,
    output logic                 BUSYWAIT
);

    localparam logic [7:0] c_lat_m1 = 8'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [LINE_BITS-1:0]    wdata_q, wdata_d;
    logic                    is_wr_q, is_wr_d;
    logic [LINE_BITS-1:0]    readdata_q, readdata_d;

    logic                    w_req;
    logic                    w_last;
    logic                    w_store_we;
    logic [LINE_BITS-1:0]    w_store_rd;
    logic                    unused_addr_bits;

    assign w_req      = READ | WRITE;
    assign w_last     = (state_q == ST_BUSY) && (cnt_q == 8'd0);
    assign w_store_we = w_last && is_wr_q;

    // Offset and upper address bits do not select a line.
    assign unused_addr_bits = ^{ADDRESS[31:ADDR_WIDTH+LINE_OFFSET_BITS],
                                ADDRESS[LINE_OFFSET_BITS-1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        readdata_d = readdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    idx_d   = ADDRESS[ADDR_WIDTH+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
                    wdata_d = WRITEDATA;
                    is_wr_d = WRITE;
                    cnt_d   = c_lat_m1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 8'd0) begin
                    if (!is_wr_q) begin
                        readdata_d = w_store_rd;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            readdata_q <= readdata_d;
        end
    end

    line_store #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_line_store (
        .clk        (CLK),
        .i_we       (w_store_we),
        .i_wr_addr  (idx_q),
        .i_wr_data  (wdata_q),
        .i_rd_addr  (idx_q),
        .o_rd_data  (w_store_rd)
    );

    // Combinational so the requester stalls in the very cycle it asks.
    assign BUSYWAIT = ((state_q == ST_IDLE) && w_req) || (state_q == ST_BUSY);
    assign READDATA = readdata_q;

endmodule

`default_nettype wire

// File: tb/tb_line_memory_responder.sv
// ============================================================================
// Module   : tb_line_memory_responder
// Purpose  : Scoreboard bench for line_memory_responder against a line model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_memory_responder;

    localparam int AW  = 8;
    localparam int LAT = 4;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ;
    logic         WRITE;
    logic [31:0]  ADDRESS;
    logic [127:0] WRITEDATA;
    logic [127:0] READDATA;
    logic         BUSYWAIT;

    line_memory_responder #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .READ      (READ),
        .WRITE     (WRITE),
        .ADDRESS   (ADDRESS),
        .WRITEDATA (WRITEDATA),
        .READDATA  (READDATA),
        .BUSYWAIT  (BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference model: line array plus the last line a read returned.
    logic [127:0] ref_mem [int];
    logic [127:0] ref_rd = '0;
    logic [127:0] exp_q [$];

    bit           mon_en  = 1'b0;
    logic [127:0] hold_rd = '0;
    int           bcnt    = 0;
    bit           prev_bw = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ref_line(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 128'd0;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) & ((32'd1 << AW) - 1));
    endfunction

    function automatic void predict(input bit wr, input logic [31:0] a, input logic [127:0] d);
        if (wr) ref_mem[line_of(a)] = d;
        else    ref_rd = ref_line(line_of(a));
        exp_q.push_back(ref_rd);
    endfunction

    // Monitor: every fall of BUSYWAIT marks a DONE cycle.
    always @(negedge CLK) begin
        if (!mon_en) begin
            bcnt    = 0;
            prev_bw = 1'b0;
        end else begin
            if (BUSYWAIT) begin
                bcnt++;
            end else if (prev_bw) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 128'd1, 128'd0);
                end else begin
                    hold_rd = exp_q.pop_front();
                    check("readdata_at_done", READDATA, hold_rd);
                    check("busywait_length", 128'(bcnt), 128'(LAT + 1));
                end
                bcnt = 0;
            end else begin
                check("readdata_stable", READDATA, hold_rd);
            end
            prev_bw = BUSYWAIT;
        end
    end

    // Waits until BUSYWAIT drops; scrambles inputs while busy unless held.
    task automatic wait_done(input bit scramble);
        int n;
        n = 0;
        do begin
            @(posedge CLK); #1;
            if (scramble) begin
                ADDRESS   = $urandom;
                WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
            end
            n++;
        end while (BUSYWAIT && n < LAT + 10);
        if (BUSYWAIT) check("done_timeout", 128'd1, 128'd0);
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [127:0] d);
        predict(wr, a, d);
        @(posedge CLK); #1;
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
        wait_done(1'b1);
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        int t1, t2, n, idx;
        bit rd, wr;
        logic [31:0]  a;
        logic [127:0] d;
        int lines [5] = '{4, 8, 32, 33, 51};

        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busywait", 128'(BUSYWAIT), 128'd0);
        check("reset_readdata", READDATA, 128'd0);
        RESET = 1'b1;
        mon_en = 1'b1;

        // Directed: write/read, offsets, alias, simultaneous, unwritten line.
        issue(0, 1, 32'h0000_0040, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
        issue(1, 0, 32'h0000_004C, '0);
        issue(1, 0, 32'h0000_0044, '0);
        issue(1, 0, 32'h0000_004F, '0);
        issue(1, 0, 32'h0000_1040, '0);
        issue(1, 1, 32'h0000_0080, 128'h1234);
        issue(1, 0, 32'h0000_0100, '0);
        issue(1, 0, 32'h0000_0080, '0);

        // Reset during the second BUSY cycle of a write aborts the commit.
        @(posedge CLK); #1;
        WRITE = 1'b1; ADDRESS = 32'h0000_00C0; WRITEDATA = 128'hFFFF;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        mon_en = 1'b0;
        RESET = 1'b0; WRITE = 1'b0;
        #1;
        check("midreset_busywait", 128'(BUSYWAIT), 128'd0);
        check("midreset_readdata", READDATA, 128'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        ref_rd  = '0;
        hold_rd = '0;
        mon_en  = 1'b1;
        issue(1, 0, 32'h0000_00C0, '0);

        // Back-to-back reads with READ held through DONE.
        issue(0, 1, 32'h0000_0300, 128'hCAFE_0000_BEEF_0000_1111_2222_3333_4444);
        predict(0, 32'h0000_0300, '0);
        predict(0, 32'h0000_0300, '0);
        @(posedge CLK); #1;
        READ = 1'b1; ADDRESS = 32'h0000_0300;
        wait_done(1'b0);
        t1 = cyc;
        n = 0;
        while (!BUSYWAIT && n < 4) begin @(posedge CLK); #1; n++; end
        wait_done(1'b0);
        t2 = cyc;
        READ = 1'b0;
        check("b2b_spacing", 128'(t2 - t1), 128'(LAT + 2));

        // Randomized traffic over a handful of lines with noisy offset/upper bits.
        for (int i = 0; i < 40; i++) begin
            idx = lines[$urandom_range(0, 4)];
            a   = ($urandom & 32'hFFFF_F000) | (32'(idx) << 4) | 32'($urandom_range(0, 15));
            d   = {$urandom, $urandom, $urandom, $urandom};
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            issue(rd, wr, a, d);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(posedge CLK); n++; end
        repeat (2) @(posedge CLK);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
